// File: rtl/aes256_enc_iter_if.sv
// Handshake bundle between the AES-256 key expander/producer, the iterative
// encryption core and its ciphertext consumer.
interface aes256_enc_iter_if #(
   parameter int unsigned NR   = 14,
   parameter int unsigned RK_W = 128 * (NR + 1)
);
   logic [RK_W-1:0] roundKeys;
   logic            in_valid;
   logic            in_ready;
   logic [127:0]    in_block;
   logic            out_valid;
   logic            out_ready;
   logic [127:0]    out_block;
   logic            busy;

   modport master (
      output roundKeys, in_valid, in_block, out_ready,
      input  in_ready, out_valid, out_block, busy
   );

   modport slave (
      input  roundKeys, in_valid, in_block, out_ready,
      output in_ready, out_valid, out_block, busy
   );
endinterface

// File: rtl/aes256_enc_iter.sv
// Iterative AES-256 encryption core: one round per clock from a pre-expanded
// 15x128-bit round-key bus, one block in flight, valid/ready on both sides.
module aes256_enc_iter #(
   parameter int unsigned NR   = 14,
   parameter int unsigned RK_W = 128 * (NR + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   aes256_enc_iter_if.slave   bus
);

   if (NR != 14) begin : g_bad_nr
      $error("aes256_enc_iter supports only NR = 14");
   end

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

   localparam logic [3:0] LAST_RND = 4'd14;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte, so the bit offset of entry x is 8*(255-x).
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte i lives at [127-8i -: 8]; row = i%4, column = i/4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned row = 0; row < 4; row++) begin
            r[127-8*(4*c+row) -: 8] = sbox(s[127-8*(4*((c+row)%4)+row) -: 8]);
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   logic [127:0] rk [NR+1];

   for (genvar r = 0; r <= NR; r++) begin : g_rk
      assign rk[r] = bus.roundKeys[RK_W-1-128*r -: 128];
   end

   state_e       state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] st_q, st_d;
   logic [127:0] out_q, out_d;
   logic         out_valid_q, out_valid_d;

   logic [127:0] sb_sr;
   logic [127:0] round_out;

   always_comb begin
      sb_sr     = sub_shift(st_q);
      round_out = (rnd_q == LAST_RND) ? (sb_sr ^ rk[rnd_q])
                                      : (mix_columns(sb_sr) ^ rk[rnd_q]);
   end

   always_comb begin
      state_d     = state_q;
      rnd_d       = rnd_q;
      st_d        = st_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               st_d    = bus.in_block ^ rk[0];
               rnd_d   = 4'd1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (rnd_q == LAST_RND) begin
               out_d       = round_out;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               st_d  = round_out;
               rnd_d = rnd_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rnd_q       <= '0;
         st_q        <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         st_q        <= st_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_block = out_q;

endmodule

// File: tb/tb_aes256_enc_iter.sv
// Directed bench for aes256_enc_iter: FIPS-197 vectors, backpressure,
// back-to-back traffic, mid-operation reset and randomised blocks.
module tb_aes256_enc_iter;

   localparam int unsigned NR   = 14;
   localparam int unsigned RK_W = 1920;

   localparam logic [255:0] KEY_C3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT_Z  = 128'hdc95c078a2408989ad48a21492842087;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes256_enc_iter_if #(.NR(NR), .RK_W(RK_W)) bus ();

   aes256_enc_iter #(.NR(NR), .RK_W(RK_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int nvec = 0;
   int nerr = 0;
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box derived from the GF(2^8) inverse and affine map, not from a table.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         if (v != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
         end
         sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   function automatic logic [1919:0] expand(input logic [255:0] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] o;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end else if (i % 8 == 4) begin
            t = subword(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int i = 0; i < 60; i++) o[1919-32*i -: 32] = w[i];
      return o;
   endfunction

   function automatic logic [127:0] ref_enc(input logic [1919:0] rks, input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] k, o;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[1919-8*i -: 8];
      for (int r = 1; r <= 14; r++) begin
         k = rks[1919-128*r -: 128];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[4*c+row] = sb[s[4*((c+row)%4)+row]];
         if (r < 14) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
               s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
         end else begin
            s = t;
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while IDLE; returns at the negedge after the accept edge.
   task automatic send(input logic [127:0] blk);
      check("in_ready_before_send", 128'(bus.in_ready), 128'd1);
      bus.in_block = blk;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_block = ~blk;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int           lat;
      logic [127:0] held;
      logic [127:0] blks [3];
      logic [127:0] exps [3];
      logic [127:0] got  [3];
      int           acc  [3];
      int           na, no, t, stall;
      logic         seen;
      logic [255:0] key;
      logic [127:0] pt;

      bus.roundKeys = '0;
      bus.in_valid  = 1'b0;
      bus.in_block  = '0;
      bus.out_ready = 1'b0;
      build_sbox();

      // Reset values, during and after reset
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 128'(bus.in_ready), 128'd1);
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_out_block", bus.out_block, 128'd0);
      check("rst_busy", 128'(bus.busy), 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

      // FIPS-197 C.3, out_ready already high before out_valid
      bus.roundKeys = expand(KEY_C3);
      bus.out_ready = 1'b1;
      send(PT_C3);
      check("c3_busy", 128'(bus.busy), 128'd1);
      wait_out(lat);
      check("c3_latency", 128'(lat), 128'd14);
      check("c3_block", bus.out_block, CT_C3);
      check("c3_done_in_ready", 128'(bus.in_ready), 128'd0);
      @(posedge clk);
      @(negedge clk);
      check("c3_idle_in_ready", 128'(bus.in_ready), 128'd1);
      check("c3_idle_out_valid", 128'(bus.out_valid), 128'd0);

      // Zero key / zero block with 10 cycles of backpressure
      bus.roundKeys = expand(256'd0);
      bus.out_ready = 1'b0;
      send(128'd0);
      wait_out(lat);
      check("h_latency", 128'(lat), 128'd14);
      check("h_block", bus.out_block, CT_Z);
      held = bus.out_block;
      bus.in_block = 128'd0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_out_block", bus.out_block, held);
         check("bp_out_valid", 128'(bus.out_valid), 128'd1);
         check("bp_in_ready", 128'(bus.in_ready), 128'd0);
         check("bp_busy", 128'(bus.busy), 128'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
      check("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
      // in_valid held across DONE->IDLE is taken on the first IDLE cycle
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("held_accept_busy", 128'(bus.busy), 128'd1);
      wait_out(lat);
      check("held_latency", 128'(lat), 128'd14);
      check("held_block", bus.out_block, CT_Z);
      drain();

      // Back-to-back: in_valid held with three queued blocks
      bus.roundKeys = expand(KEY_C3);
      blks[0] = PT_C3;
      blks[1] = 128'h0123456789abcdeffedcba9876543210;
      blks[2] = 128'hffffffffffffffffffffffffffffffff;
      exps[0] = CT_C3;
      exps[1] = ref_enc(bus.roundKeys, blks[1]);
      exps[2] = ref_enc(bus.roundKeys, blks[2]);
      got[0] = '0; got[1] = '0; got[2] = '0;
      acc[0] = 0; acc[1] = 0; acc[2] = 0;
      na = 0; no = 0; t = 0;
      bus.out_ready = 1'b1;
      bus.in_block  = blks[0];
      bus.in_valid  = 1'b1;
      while (no < 3 && t < 200) begin
         if (bus.in_valid && bus.in_ready) begin
            if (na < 3) acc[na] = t;
            na++;
         end
         if (bus.out_valid && bus.out_ready) begin
            got[no] = bus.out_block;
            no++;
         end
         @(posedge clk);
         @(negedge clk);
         t++;
         if (na < 3) bus.in_block = blks[na];
         else bus.in_valid = 1'b0;
      end
      check("b2b_accepts", 128'(na), 128'd3);
      check("b2b_outputs", 128'(no), 128'd3);
      check("b2b_spacing_01", 128'(acc[1] - acc[0]), 128'd16);
      check("b2b_spacing_12", 128'(acc[2] - acc[1]), 128'd16);
      check("b2b_block0", got[0], exps[0]);
      check("b2b_block1", got[1], exps[1]);
      check("b2b_block2", got[2], exps[2]);
      @(posedge clk);
      @(negedge clk);

      // Reset asserted while round 7 is in progress
      send(PT_C3);
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 128'(bus.out_valid), 128'd0);
      check("abort_out_block", bus.out_block, 128'd0);
      check("abort_busy", 128'(bus.busy), 128'd0);
      check("abort_in_ready", 128'(bus.in_ready), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      check("abort_no_pulse", 128'(seen), 128'd0);
      check("abort_in_ready_after", 128'(bus.in_ready), 128'd1);
      send(PT_C3);
      wait_out(lat);
      check("abort_rerun_latency", 128'(lat), 128'd14);
      check("abort_rerun_block", bus.out_block, CT_C3);
      drain();

      // Random keys and blocks with random output stalls
      for (int n = 0; n < 1000; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         bus.roundKeys = expand(key);
         bus.out_ready = 1'b0;
         send(pt);
         wait_out(lat);
         stall = int'($urandom_range(0, 3));
         repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
         end
         check("rand_valid", 128'(bus.out_valid), 128'd1);
         check("rand_block", bus.out_block, ref_enc(bus.roundKeys, pt));
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/aes256_enc_iter.md
Name: aes256_enc_iter

Overview:
- Iterative AES-256 encryption core; the stage directly downstream of the combinational key expander.
- Consumes the expander's 15x128-bit round-key bus and encrypts one 128-bit block per transaction, executing one round per clock.
- Feeds the GCM datapath: counter-block encryption and hash subkey H = E(K, 0^128).
- Valid/ready handshake on both sides; one block in flight.

Parameters:
NR, 14, number of rounds; only 14 is supported (elaboration error otherwise).
RK_W, 1920, round-key bus width = 128*(NR+1).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
roundKeys  input  1920  round keys from key expander; rk[r] = roundKeys[1919-128*r -: 128], r=0..14.
in_valid  input  1  plaintext block valid.
in_ready  output  1  core can accept a block (high only in IDLE).
in_block  input  128  plaintext, byte 0 in [127:120], column-major per FIPS-197.
out_valid  output  1  ciphertext valid.
out_ready  input  1  downstream accepts ciphertext.
out_block  output  128  ciphertext, same byte order as in_block.
busy  output  1  high in ROUND and DONE; upstream must hold roundKeys stable while busy=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, round counter=0, state register=0, out_block=0, out_valid=0, busy=0, in_ready=1 after reset release.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: st <= in_block ^ rk[0], rnd <= 1, go to ROUND.
- ROUND: each cycle applies round rnd with rk[rnd].
  - rnd 1..13: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
  - rnd 14: SubBytes -> ShiftRows -> AddRoundKey (no MixColumns). Result is loaded into out_block, out_valid <= 1, go to DONE.
  - Otherwise rnd <= rnd+1 (4-bit counter; never exceeds 14).
- DONE:
  - out_block and out_valid held stable until out_valid&out_ready.
  - On that handshake: out_valid <= 0, go to IDLE.
  - in_ready=0 throughout DONE; no overlap of output handshake with new accept.
- Latency: 14 clocks from the accept edge to the edge asserting out_valid, with out_ready held high. Throughput: 1 block per 16 cycles (accept, 14 rounds, DONE->IDLE).
- Arithmetic:
  - SubBytes uses 16 parallel lookups of the FIPS-197 forward S-box.
  - MixColumns uses xtime over GF(2^8) with reduction polynomial 0x11B.
  - ShiftRows rotates row r left by r bytes.
  - All operations are combinational within a single cycle.
- roundKeys is sampled live every cycle. A change while busy=1 corrupts the result; this is an upstream protocol violation and is not detected.
- Boundaries:
  - in_valid while busy: ignored; no accept; block not captured.
  - in_valid held across DONE->IDLE: accepted on the first IDLE cycle.
  - out_ready high before out_valid: no effect.
  - rst_n asserted mid-ROUND or mid-DONE: immediate abort to reset values; partial result discarded; no out_valid pulse.
  - in_block is sampled only on the accept edge; later changes have no effect.

Test Plan:
- FIPS-197 C.3: key 000102...1f expanded into roundKeys; in_block 00112233445566778899aabbccddeeff -> out_block 8ea2b7ca516745bfeafc49904b496089, out_valid exactly 14 cycles after accept.
- Zero key, zero block (GCM H) -> out_block dc95c078a2408989ad48a21492842087.
- Backpressure: out_ready low 10 cycles after out_valid -> out_block/out_valid stable, in_ready=0, busy=1; raise out_ready -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with 3 blocks queued, out_ready=1 -> 3 correct ciphertexts, accepts spaced 16 cycles; in_valid during ROUND is never accepted.
- Reset mid-operation: assert rst_n=0 at round 7 -> out_valid=0, out_block=0, in_ready=1 after release; next encryption of the C.3 vector is correct.
- Random: 1000 random keys/blocks with random out_ready stalls vs software AES-256 model -> bit-exact match.
